// File: rtl/pair_serial_tx.sv
// pair_serial_tx: sends a latched a/b pair as a framed serial word.
// Frame: start(0), a, b, even parity (a^b), stop(1); each symbol lasts
// CLKS_PER_BIT cycles. Line idles high. done pulses for one cycle in
// the first IDLE cycle after the stop symbol.
//
//   state  | meaning
//   IDLE   | line high, ready to accept a pair
//   START  | start symbol (0)
//   BIT_A  | latched a
//   BIT_B  | latched b
//   PARITY | latched a ^ b
//   STOP   | stop symbol (1)
module pair_serial_tx #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic a,
    input  logic b,
    input  logic in_valid,
    output logic in_ready,
    output logic tx,
    output logic busy,
    output logic done
);

    // At least one bit so CLKS_PER_BIT=1 still has a legal counter.
    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        BIT_A  = 3'd2,
        BIT_B  = 3'd3,
        PARITY = 3'd4,
        STOP   = 3'd5
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] bit_cnt;
    logic             a_q;
    logic             b_q;

    assign in_ready = (state == IDLE);

    // Frame sequencer; tx, busy and done are registered alongside the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            bit_cnt <= '0;
            a_q     <= 1'b0;
            b_q     <= 1'b0;
            tx      <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == IDLE) begin
                bit_cnt <= '0;
                if (in_valid) begin
                    a_q   <= a;
                    b_q   <= b;
                    state <= START;
                    tx    <= 1'b0;
                    busy  <= 1'b1;
                end
            end else if (bit_cnt != LAST) begin
                bit_cnt <= bit_cnt + 1'b1;
            end else begin
                bit_cnt <= '0;
                case (state)
                    START: begin
                        state <= BIT_A;
                        tx    <= a_q;
                    end
                    BIT_A: begin
                        state <= BIT_B;
                        tx    <= b_q;
                    end
                    BIT_B: begin
                        state <= PARITY;
                        tx    <= a_q ^ b_q;
                    end
                    PARITY: begin
                        state <= STOP;
                        tx    <= 1'b1;
                    end
                    default: begin
                        state <= IDLE;
                        tx    <= 1'b1;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pair_serial_tx.sv
// Bench for pair_serial_tx: directed frame table, multi-cycle corner
// sequences, CLKS_PER_BIT=1 instance and randomized traffic against a
// frame-timing model.
module tb_pair_serial_tx;

    localparam int N = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst4_n, a4, b4, v4, ready4, tx4, busy4, done4;
    logic rst1_n, a1, b1, v1, ready1, tx1, busy1, done1;

    pair_serial_tx #(.CLKS_PER_BIT(N)) dut4 (
        .clk(clk), .rst_n(rst4_n), .a(a4), .b(b4), .in_valid(v4),
        .in_ready(ready4), .tx(tx4), .busy(busy4), .done(done4)
    );

    pair_serial_tx #(.CLKS_PER_BIT(1)) dut1 (
        .clk(clk), .rst_n(rst1_n), .a(a1), .b(b1), .in_valid(v1),
        .in_ready(ready1), .tx(tx1), .busy(busy1), .done(done1)
    );

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic       a;
        logic       b;
        logic       tog;
        logic [4:0] exp;   // start, a, b, parity, stop (msb first)
    } vec_t;

    vec_t vecs[4];

    task automatic chk(input string nm, input logic act, input logic exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    task automatic chk4(input string tag, input logic etx, input logic ebusy, input logic edone);
        chk({tag, " tx"}, tx4, etx);
        chk({tag, " busy"}, busy4, ebusy);
        chk({tag, " in_ready"}, ready4, !ebusy);
        chk({tag, " done"}, done4, edone);
    endtask

    task automatic chk1(input string tag, input logic etx, input logic ebusy, input logic edone);
        chk({tag, " tx"}, tx1, etx);
        chk({tag, " busy"}, busy1, ebusy);
        chk({tag, " in_ready"}, ready1, !ebusy);
        chk({tag, " done"}, done1, edone);
    endtask

    // One full frame on dut4, checked cycle by cycle through done and one idle cycle.
    task automatic frame4(input logic a, input logic b, input logic tog,
                          input logic [4:0] exp, input string tag);
        logic [4:0] t;
        @(negedge clk);
        a4 = a; b4 = b; v4 = 1'b1;
        for (int c = 1; c <= 5*N+2; c++) begin
            @(negedge clk);
            if (c <= 5*N) begin
                t = exp << ((c-1)/N);
                chk4($sformatf("%s c%0d", tag, c), t[4], 1'b1, 1'b0);
            end else begin
                chk4($sformatf("%s c%0d", tag, c), 1'b1, 1'b0, c == 5*N+1);
            end
            if (tog && c <= 5*N) begin
                a4 = ~a4; b4 = ~b4; v4 = ~v4;
            end else begin
                v4 = 1'b0;
            end
        end
    endtask

    initial begin
        logic [4:0] t;
        logic [4:0] fb;
        logic       act, have;
        int         fs, k;

        vecs[0] = '{a: 1'b1, b: 1'b0, tog: 1'b0, exp: 5'b01011};
        vecs[1] = '{a: 1'b0, b: 1'b1, tog: 1'b1, exp: 5'b00111};
        vecs[2] = '{a: 1'b1, b: 1'b1, tog: 1'b0, exp: 5'b01101};
        vecs[3] = '{a: 1'b0, b: 1'b0, tog: 1'b1, exp: 5'b00001};

        rst4_n = 1'b0; rst1_n = 1'b0;
        a4 = 1'b0; b4 = 1'b0; v4 = 1'b1;
        a1 = 1'b0; b1 = 1'b0; v1 = 1'b1;
        repeat (3) @(negedge clk);
        chk4("reset", 1'b1, 1'b0, 1'b0);
        chk1("reset1", 1'b1, 1'b0, 1'b0);
        v4 = 1'b0; v1 = 1'b0;
        rst4_n = 1'b1; rst1_n = 1'b1;

        // idle after reset
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            chk4($sformatf("idle c%0d", c), 1'b1, 1'b0, 1'b0);
        end

        for (int i = 0; i < 4; i++)
            frame4(vecs[i].a, vecs[i].b, vecs[i].tog, vecs[i].exp, $sformatf("vec%0d", i));

        // back-to-back: (1,1) then (0,1) with in_valid held high
        @(negedge clk);
        a4 = 1'b1; b4 = 1'b1; v4 = 1'b1;
        for (int c = 1; c <= 43; c++) begin
            @(negedge clk);
            if (c <= 20) begin
                t = 5'b01101 << ((c-1)/N);
                chk4($sformatf("b2b c%0d", c), t[4], 1'b1, 1'b0);
            end else if (c == 21 || c == 42 || c == 43) begin
                chk4($sformatf("b2b c%0d", c), 1'b1, 1'b0, c != 43);
            end else begin
                t = 5'b00111 << ((c-22)/N);
                chk4($sformatf("b2b c%0d", c), t[4], 1'b1, 1'b0);
            end
            if (c == 1) begin a4 = 1'b0; b4 = 1'b1; end
            if (c == 22) v4 = 1'b0;
        end

        // reset during BIT_B
        @(negedge clk);
        a4 = 1'b0; b4 = 1'b1; v4 = 1'b1;
        for (int c = 1; c <= 2*N+2; c++) begin
            @(negedge clk);
            t = 5'b00111 << ((c-1)/N);
            chk4($sformatf("rstmid c%0d", c), t[4], 1'b1, 1'b0);
            v4 = 1'b0;
        end
        rst4_n = 1'b0;
        #1;
        chk4("rstmid async", 1'b1, 1'b0, 1'b0);
        v4 = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk4($sformatf("rstheld c%0d", c), 1'b1, 1'b0, 1'b0);
        end
        v4 = 1'b0;
        rst4_n = 1'b1;
        for (int c = 0; c < 25; c++) begin
            @(negedge clk);
            chk4($sformatf("postrst c%0d", c), 1'b1, 1'b0, 1'b0);
        end
        frame4(1'b1, 1'b0, 1'b0, 5'b01011, "afterrst");

        // CLKS_PER_BIT = 1
        @(negedge clk);
        a1 = 1'b1; b1 = 1'b1; v1 = 1'b1;
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            v1 = 1'b0;
            if (c <= 5) begin
                t = 5'b01101 << (c-1);
                chk1($sformatf("cpb1 c%0d", c), t[4], 1'b1, 1'b0);
            end else begin
                chk1($sformatf("cpb1 c%0d", c), 1'b1, 1'b0, c == 6);
            end
        end

        // randomized traffic against frame-timing model
        have = 1'b0; fs = 0; k = 0; fb = '0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            k++;
            act = have && (k >= fs+1) && (k <= fs+5*N);
            if (act) begin
                t = fb << ((k-fs-1)/N);
                chk4($sformatf("rand k%0d", k), t[4], 1'b1, 1'b0);
            end else begin
                chk4($sformatf("rand k%0d", k), 1'b1, 1'b0, have && (k == fs+5*N+1));
            end
            a4 = 1'($urandom_range(0, 1));
            b4 = 1'($urandom_range(0, 1));
            v4 = ($urandom_range(0, 3) == 0);
            if (v4 && !act) begin
                fs = k;
                have = 1'b1;
                fb = {1'b0, a4, b4, a4 ^ b4, 1'b1};
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
